frame_timer: RTL and testbench

//   Memory-mapped bus responder for the CPU-side bus that control drives (addr/data/rw, chip select).

---
 rtl/frame_timer_pkg.sv | 26 ++
 rtl/frame_timer_rise_detect.sv | 26 ++
 rtl/frame_timer.sv | 164 ++++++++++++++++
 tb/tb_frame_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_timer_pkg.sv
// Shared constants for the frame_timer bus responder: register offsets,
// STATUS/CTRL bit positions and the decoded base address.
package frame_timer_pkg;

  localparam logic [15:0] FT_BASE_ADDR = 16'hEFE0;

  typedef enum logic [3:0] {
    FT_FRAME_LO = 4'd0,
    FT_FRAME_HI = 4'd1,
    FT_STATUS   = 4'd2,
    FT_CTRL     = 4'd3,
    FT_LINE_CMP = 4'd4,
    FT_VPOS     = 4'd5,
    FT_HPOS     = 4'd6,
    FT_SCRATCH  = 4'd7
  } ft_reg_e;

  localparam int ST_VBLANK = 0;
  localparam int ST_LINE   = 1;
  localparam int ST_HSYNC  = 6;
  localparam int ST_VSYNC  = 7;

  localparam int CTRL_VBLANK_IE = 0;
  localparam int CTRL_LINE_IE   = 1;

endpackage

// File: rtl/frame_timer_rise_detect.sv
// Registered rising-edge detector; the first clock after reset only loads
// the history register so a level already high at release is not an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;
  logic armed_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = d_i & ~d_q & armed_q;

endmodule

// File: rtl/frame_timer.sv
// Frame counter / raster status responder with vblank and optional scanline-compare irq.
// Scanline compare (LINE_CMP, STATUS[1], CTRL[1]) exists only when SCANLINE_CMP_EN is defined.
module frame_timer
  import frame_timer_pkg::*;
#(
  parameter int         FRAME_W   = 16,
  parameter logic [6:0] RESET_CMP = 7'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic       cs,
  input  logic       rw,
  input  logic [7:0] di,
  output logic [7:0] dout,
  input  logic       vsync,
  input  logic       hsync,
  input  logic [6:0] vpos,
  input  logic [7:0] hpos,
  output logic       irq
);

  logic wr_en;
  logic rd_en;
  logic vs_rise;

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         shadow_q, shadow_d;
  logic [7:0]         scratch_q, scratch_d;
  logic [7:0]         dout_q, dout_d;
  logic               vblank_q, vblank_d;
  logic               ctrl_vb_q, ctrl_vb_d;

  logic               line_flag;
  logic               ctrl_line;
  logic [6:0]         line_cmp;
  logic [7:0]         status_rd;
  logic [7:0]         ctrl_rd;

  assign wr_en = cs & rw;
  assign rd_en = cs & ~rw;

  rise_detect u_vsync_rise (
    .clk    (clk),
    .reset  (reset),
    .d_i    (vsync),
    .rise_o (vs_rise)
  );

`ifdef SCANLINE_CMP_EN
  logic [6:0] line_cmp_q, line_cmp_d;
  logic [6:0] vpos_q;
  logic       line_flag_q, line_flag_d;
  logic       ctrl_line_q, ctrl_line_d;

  always_comb begin
    line_cmp_d  = line_cmp_q;
    line_flag_d = line_flag_q;
    ctrl_line_d = ctrl_line_q;
    if (wr_en && addr == FT_LINE_CMP) line_cmp_d  = di[6:0];
    if (wr_en && addr == FT_CTRL)     ctrl_line_d = di[CTRL_LINE_IE];
    if (wr_en && addr == FT_STATUS && di[ST_LINE]) line_flag_d = 1'b0;
    // Entering the compare line sets the flag, overriding a same-cycle clear.
    if (vpos != vpos_q && vpos == line_cmp_q) line_flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cmp_q  <= RESET_CMP;
      vpos_q      <= 7'd0;
      line_flag_q <= 1'b0;
      ctrl_line_q <= 1'b0;
    end else begin
      line_cmp_q  <= line_cmp_d;
      vpos_q      <= vpos;
      line_flag_q <= line_flag_d;
      ctrl_line_q <= ctrl_line_d;
    end
  end

  assign line_cmp  = line_cmp_q;
  assign line_flag = line_flag_q;
  assign ctrl_line = ctrl_line_q;
`else
  assign line_cmp  = 7'd0;
  assign line_flag = 1'b0;
  assign ctrl_line = 1'b0;
`endif

  always_comb begin
    status_rd            = 8'h00;
    status_rd[ST_VBLANK] = vblank_q;
    status_rd[ST_LINE]   = line_flag;
    status_rd[ST_HSYNC]  = hsync;
    status_rd[ST_VSYNC]  = vsync;
    ctrl_rd                 = 8'h00;
    ctrl_rd[CTRL_VBLANK_IE] = ctrl_vb_q;
    ctrl_rd[CTRL_LINE_IE]   = ctrl_line;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    frame_d   = frame_q;
    shadow_d  = shadow_q;
    scratch_d = scratch_q;
    vblank_d  = vblank_q;
    ctrl_vb_d = ctrl_vb_q;
    dout_d    = 8'h00;

    if (wr_en) begin
      case (addr)
        FT_STATUS:  if (di[ST_VBLANK]) vblank_d = 1'b0;
        FT_CTRL:    ctrl_vb_d = di[CTRL_VBLANK_IE];
        FT_SCRATCH: scratch_d = di;
        default:    ;
      endcase
    end

    if (vs_rise) begin
      frame_d  = frame_q + FRAME_W'(1);
      vblank_d = 1'b1;
    end

    // Reads see pre-edge state, so a LO read racing an increment stays coherent.
    if (rd_en) begin
      case (addr)
        FT_FRAME_LO: begin
          dout_d   = frame_q[7:0];
          shadow_d = frame_q[15:8];
        end
        FT_FRAME_HI: dout_d = shadow_q;
        FT_STATUS:   dout_d = status_rd;
        FT_CTRL:     dout_d = ctrl_rd;
        FT_LINE_CMP: dout_d = {1'b0, line_cmp};
        FT_VPOS:     dout_d = {1'b0, vpos};
        FT_HPOS:     dout_d = hpos;
        FT_SCRATCH:  dout_d = scratch_q;
        default:     dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q   <= '0;
      shadow_q  <= 8'h00;
      scratch_q <= 8'h00;
      vblank_q  <= 1'b0;
      ctrl_vb_q <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      frame_q   <= frame_d;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
      vblank_q  <= vblank_d;
      ctrl_vb_q <= ctrl_vb_d;
      dout_q    <= dout_d;
    end
  end

  assign dout = dout_q;
  assign irq  = (vblank_q & ctrl_vb_q) | (line_flag & ctrl_line);

endmodule

// File: tb/tb_frame_timer.sv
// Self-checking bench for frame_timer: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the register map.
module tb_frame_timer;

`ifdef SCANLINE_CMP_EN
  localparam bit LINE_EN = 1'b1;
`else
  localparam bit LINE_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] addr;
  logic       cs;
  logic       rw;
  logic [7:0] di;
  logic [7:0] dout;
  logic       vsync;
  logic       hsync;
  logic [6:0] vpos;
  logic [7:0] hpos;
  logic       irq;

  frame_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .cs    (cs),
    .rw    (rw),
    .di    (di),
    .dout  (dout),
    .vsync (vsync),
    .hsync (hsync),
    .vpos  (vpos),
    .hpos  (hpos),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the register map.
  int         m_frame;
  logic [7:0] m_shadow, m_scratch, m_ctrl, exp_dout;
  logic [6:0] m_cmp, m_prev_vpos;
  bit         m_vblank, m_line, m_prev_vs, m_armed;

  task automatic m_reset();
    m_frame = 0; m_shadow = 8'h00; m_scratch = 8'h00; m_ctrl = 8'h00;
    m_cmp = 7'd0; m_prev_vpos = 7'd0; m_vblank = 0; m_line = 0;
    m_prev_vs = 0; m_armed = 0; exp_dout = 8'h00;
  endtask

  function automatic bit exp_irq();
    return (m_vblank && m_ctrl[0]) || (m_line && m_ctrl[1]);
  endfunction

  task automatic model_edge();
    bit rise, hit;
    rise = m_armed && vsync && !m_prev_vs;
    hit  = LINE_EN && (vpos != m_prev_vpos) && (vpos == m_cmp);
    exp_dout = 8'h00;
    if (cs && !rw) begin
      case (addr)
        4'd0: begin exp_dout = 8'(m_frame % 256); m_shadow = 8'(m_frame / 256); end
        4'd1: exp_dout = m_shadow;
        4'd2: exp_dout = {vsync, hsync, 4'b0000, m_line, m_vblank};
        4'd3: exp_dout = m_ctrl;
        4'd4: exp_dout = {1'b0, m_cmp};
        4'd5: exp_dout = {1'b0, vpos};
        4'd6: exp_dout = hpos;
        4'd7: exp_dout = m_scratch;
        default: exp_dout = 8'h00;
      endcase
    end
    if (cs && rw) begin
      case (addr)
        4'd2: begin if (di[0]) m_vblank = 0; if (di[1]) m_line = 0; end
        4'd3: m_ctrl = di & (LINE_EN ? 8'h03 : 8'h01);
        4'd4: if (LINE_EN) m_cmp = di[6:0];
        4'd7: m_scratch = di;
        default: ;
      endcase
    end
    if (rise) begin m_frame = (m_frame + 1) % 65536; m_vblank = 1; end
    if (hit) m_line = 1;
    m_prev_vs = vsync; m_prev_vpos = vpos; m_armed = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("dout", dout, exp_dout);
    check("irq", irq, exp_irq());
  endtask

  task automatic do_reset();
    cs = 0; rw = 0;
    reset = 1;
    m_reset();
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_irq", irq, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1; rw = 1; addr = a; di = d;
    step();
    cs = 0; rw = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    cs = 1; rw = 0; addr = a;
    step();
    cs = 0;
  endtask

  task automatic pulse_vs();
    vsync = 1; step();
    vsync = 0; step();
  endtask

  initial begin
    reset = 1; cs = 0; rw = 0; addr = 4'd0; di = 8'h00;
    vsync = 0; hsync = 0; vpos = 7'd0; hpos = 8'h00;
    m_reset();

    // 1: three frames counted
    do_reset();
    repeat (3) pulse_vs();
    rd(4'd0); check("t1_lo", dout, 8'h03);
    rd(4'd1); check("t1_hi", dout, 8'h00);
    rd(4'd2); check("t1_vblank", dout[0], 1'b1);

    // 2: shadow coherence across LO/HI boundary, including read racing an increment
    do_reset();
    repeat (255) pulse_vs();
    vsync = 1;
    rd(4'd0); check("t2_lo_race", dout, 8'hFF);
    vsync = 0; step();
    pulse_vs();
    rd(4'd1); check("t2_hi_shadow", dout, 8'h00);
    rd(4'd0); check("t2_lo_fresh", dout, 8'h01);
    rd(4'd1); check("t2_hi_fresh", dout, 8'h01);

    // 3: vblank irq, W1C, set-beats-clear
    do_reset();
    wr(4'd3, 8'h01);
    vsync = 1; step(); check("t3_irq_set", irq, 1'b1);
    vsync = 0;
    wr(4'd2, 8'h01); check("t3_irq_clr", irq, 1'b0);
    vsync = 1;
    wr(4'd2, 8'h01); check("t3_set_wins", irq, 1'b1);
    vsync = 0;
    rd(4'd2); check("t3_flag_kept", dout[0], 1'b1);

    // 4: scanline compare sweep
    do_reset();
    wr(4'd4, 8'd40);
    wr(4'd3, 8'h02);
    for (int v = 0; v <= 80; v++) begin
      vpos = 7'(v);
      step();
      check("t4_irq", irq, LINE_EN && v >= 40);
    end
    rd(4'd2); check("t4_line_flag", dout[1], LINE_EN);
    rd(4'd4); check("t4_cmp_rd", dout, LINE_EN ? 8'd40 : 8'd0);
    vpos = 7'd0;

    // 5: vsync high across reset release, then reset in the middle of a read
    vsync = 1;
    do_reset();
    step();
    rd(4'd0); check("t5_no_edge", dout, 8'h00);
    vsync = 0;
    wr(4'd7, 8'h5A);
    rd(4'd7); check("t5_pre", dout, 8'h5A);
    cs = 1; rw = 0; addr = 4'd7;
    #2 reset = 1;
    #1 check("t5_rst_dout", dout, 8'h00);
    do_reset();

    // 6: scratch, unmapped offset, idle bus
    wr(4'd7, 8'hA5);
    rd(4'd7);  check("t6_scratch", dout, 8'hA5);
    rd(4'd12); check("t6_unmapped", dout, 8'h00);
    step();    check("t6_idle", dout, 8'h00);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cs    = 1'($urandom_range(0, 1));
      rw    = 1'($urandom_range(0, 1));
      addr  = 4'($urandom_range(0, 15));
      di    = 8'($urandom);
      if (cs && rw && addr == 4'd4) di = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) vsync = ~vsync;
      hsync = 1'($urandom);
      if ($urandom_range(0, 3) == 0) vpos = 7'($urandom_range(0, 15));
      hpos  = 8'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
